// File: rtl/mole_frame_painter.sv
// mole_frame_painter: turns the 3-bit game state into a 160x120 pixel stream
// for the vga_adapter. Every state change repaints the background, then the
// four mole holes, and the active mole's hole is drawn in yellow.
module mole_frame_painter #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int HOLE_SIZE  = 16,
  parameter int HOLE_X0    = 12,
  parameter int HOLE_PITCH = 40,
  parameter int HOLE_Y0    = 52
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state_i,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  localparam int OW = (HOLE_SIZE > 1) ? $clog2(HOLE_SIZE) : 1;

  localparam logic [7:0]    X_LAST   = 8'(SCREEN_W - 1);
  localparam logic [6:0]    Y_LAST   = 7'(SCREEN_H - 1);
  localparam logic [OW-1:0] OFF_LAST = OW'(HOLE_SIZE - 1);

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BLUE   = 3'b001;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_YELLOW = 3'b110;

  localparam logic [2:0] ST_GAME     = 3'b001;
  localparam logic [2:0] ST_MOLE1    = 3'b010;
  localparam logic [2:0] ST_MOLE4    = 3'b101;
  localparam logic [2:0] ST_GAMEOVER = 3'b110;

  typedef enum logic [1:0] {LATCH, CLEAR, HOLES, IDLE} paint_state_t;

  paint_state_t  fsm;
  logic [2:0]    state_q;
  logic [1:0]    hole_idx;
  logic [OW-1:0] off_x;
  logic [OW-1:0] off_y;

  logic [1:0]    hole_n;
  logic [OW-1:0] off_x_n;
  logic [OW-1:0] off_y_n;
  logic [7:0]    hole_x_n;
  logic [6:0]    hole_y_n;
  logic          hole_last;
  logic          change;

  // Game and the four mole states share the green field with holes on top.
  function automatic logic in_game(input logic [2:0] sq);
    return (sq >= ST_GAME) && (sq <= ST_MOLE4);
  endfunction

  function automatic logic [2:0] background(input logic [2:0] sq);
    if (sq == ST_GAMEOVER)
      return COL_RED;
    else if (in_game(sq))
      return COL_GREEN;
    else
      return COL_BLUE;
  endfunction

  // Mole1..Mole4 are encoded 010..101, so hole i is lit when state is i+2.
  function automatic logic [2:0] hole_colour(input logic [2:0] sq, input logic [1:0] idx);
    return (sq == ({1'b0, idx} + ST_MOLE1)) ? COL_YELLOW : COL_BLACK;
  endfunction

  assign change = (state_i != state_q);

  // Next pixel position inside the hole sweep: offsets walk each hole in raster order.
  always_comb begin
    hole_n  = hole_idx;
    off_x_n = off_x + 1'b1;
    off_y_n = off_y;
    if (off_x == OFF_LAST) begin
      off_x_n = '0;
      if (off_y == OFF_LAST) begin
        off_y_n = '0;
        hole_n  = hole_idx + 2'd1;
      end else begin
        off_y_n = off_y + 1'b1;
      end
    end
    hole_last = (hole_idx == 2'd3) && (off_x == OFF_LAST) && (off_y == OFF_LAST);
    hole_x_n  = 8'(HOLE_X0) + 8'(HOLE_PITCH) * 8'(hole_n) + 8'(off_x_n);
    hole_y_n  = 7'(HOLE_Y0) + 7'(off_y_n);
  end

  // Painter FSM; every output is a register so the adapter sees clean pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm        <= LATCH;
      state_q    <= 3'b000;
      x          <= 8'd0;
      y          <= 7'd0;
      colour     <= 3'b000;
      plot       <= 1'b0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
      hole_idx   <= 2'd0;
      off_x      <= '0;
      off_y      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (fsm)
        LATCH: begin
          state_q  <= state_i;
          x        <= 8'd0;
          y        <= 7'd0;
          hole_idx <= 2'd0;
          off_x    <= '0;
          off_y    <= '0;
          colour   <= background(state_i);
          plot     <= 1'b1;
          busy     <= 1'b1;
          fsm      <= CLEAR;
        end
        CLEAR: begin
          if (change) begin
            fsm  <= LATCH;
            plot <= 1'b0;
            busy <= 1'b1;
            x    <= 8'd0;
            y    <= 7'd0;
          end else if ((x == X_LAST) && (y == Y_LAST)) begin
            if (in_game(state_q)) begin
              fsm    <= HOLES;
              x      <= 8'(HOLE_X0);
              y      <= 7'(HOLE_Y0);
              colour <= hole_colour(state_q, 2'd0);
            end else begin
              fsm        <= IDLE;
              plot       <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end else if (x == X_LAST) begin
            x <= 8'd0;
            y <= y + 7'd1;
          end else begin
            x <= x + 8'd1;
          end
        end
        HOLES: begin
          if (change) begin
            fsm  <= LATCH;
            plot <= 1'b0;
            busy <= 1'b1;
            x    <= 8'd0;
            y    <= 7'd0;
          end else if (hole_last) begin
            fsm        <= IDLE;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            x        <= hole_x_n;
            y        <= hole_y_n;
            colour   <= hole_colour(state_q, hole_n);
            hole_idx <= hole_n;
            off_x    <= off_x_n;
            off_y    <= off_y_n;
          end
        end
        IDLE: begin
          if (change) begin
            fsm  <= LATCH;
            plot <= 1'b0;
            busy <= 1'b1;
            x    <= 8'd0;
            y    <= 7'd0;
          end
        end
        default: fsm <= LATCH;
      endcase
    end
  end

endmodule
